// File: rtl/digit_match_pkg.sv
// digit_match_pkg
// Shared constants and the FSM state type for the digit template matcher.
//   NUM_DIGITS  : number of glyph templates (digits 0..9)
//   ROWS / COLS : image and glyph geometry (16x16 binary)
//   DIST_W      : Hamming-distance width, holds 0..256
//   REJECT_CODE : digit code reported when a match is rejected
package digit_match_pkg;

  localparam int NUM_DIGITS = 10;
  localparam int ROWS       = 16;
  localparam int COLS       = 16;
  localparam int DIST_W     = 9;

  localparam logic [3:0] REJECT_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SELECT = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/row_popcount16.sv
// row_popcount16
// Counts differing pixels between one image row and one glyph row.
// Ports:
//   img_row    in  16  image row
//   glyph_row  in  16  glyph row from one template ROM
//   mismatches out 5   popcount(img_row ^ glyph_row), 0..16
module row_popcount16
  import digit_match_pkg::*;
(
  input  logic [COLS-1:0] img_row,
  input  logic [COLS-1:0] glyph_row,
  output logic [4:0]      mismatches
);

  logic [COLS-1:0] diff;

  assign diff = img_row ^ glyph_row;

  always_comb begin
    mismatches = '0;
    for (int i = 0; i < COLS; i++) begin
      mismatches = mismatches + {4'b0000, diff[i]};
    end
  end

endmodule

// File: rtl/digit_matcher.sv
// digit_matcher
// Template-matching recognizer. Walks the 16 rows of a captured image in
// lockstep with the ten glyph ROMs, accumulates a Hamming distance per digit,
// then scans the ten distances for the closest digit (lowest index wins ties).
//
// Ports:
//   clk       in  1    system clock, rising edge
//   rst_n     in  1    asynchronous active-low reset
//   start     in  1    request a match, sampled only in IDLE
//   img_row   in  16   image row at row_addr (combinational read)
//   rom_rows  in  160  ten glyph rows at row_addr, digit d on [16d+15:16d]
//   row_addr  out 4    row index to image store and glyph ROMs
//   busy      out 1    high from the cycle after accept through done
//   done      out 1    one-cycle pulse when digit/distance update
//   digit     out 4    recognized digit, or 4'hF on reject
//   distance  out 9    best Hamming distance, 0..256
//
// Parameter REJECT_THRESH: largest best distance still accepted.
// Optional feature macro DIGIT_MATCH_REJECT_EN: when defined, a best distance
// above REJECT_THRESH reports digit 4'hF; distance still reports the best.
//
// Handshake: start is a level sampled on a rising edge only while IDLE; a
// start seen in any other state is dropped. done pulses for exactly one cycle
// and digit/distance are valid during that cycle and hold until the next done.
module digit_matcher
  import digit_match_pkg::*;
#(
  parameter int REJECT_THRESH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COLS-1:0]        img_row,
  input  logic [NUM_DIGITS*COLS-1:0] rom_rows,
  output logic [3:0]             row_addr,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             digit,
  output logic [DIST_W-1:0]      distance
);

  state_t              state, state_nxt;
  logic [3:0]          row_cnt;
  logic [3:0]          sel_idx;
  logic [DIST_W-1:0]   acc [NUM_DIGITS];
  logic [4:0]          row_diff [NUM_DIGITS];
  logic [DIST_W-1:0]   best_dist, best_dist_nxt, cand;
  logic [3:0]          best_idx, best_idx_nxt;
  logic                take_cand;
  logic [3:0]          result_digit;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_pc
    row_popcount16 u_pc (
      .img_row    (img_row),
      .glyph_row  (rom_rows[COLS*d +: COLS]),
      .mismatches (row_diff[d])
    );
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = ACCUM;
      ACCUM:  if (row_cnt == 4'(ROWS - 1)) state_nxt = SELECT;
      SELECT: if (sel_idx == 4'(NUM_DIGITS - 1)) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- best-distance scan ----------------
  // The first candidate loads unconditionally; later ones replace only when
  // strictly smaller, so equal distances keep the lower digit.
  always_comb begin
    cand          = acc[sel_idx];
    take_cand     = (sel_idx == 4'd0) || (cand < best_dist);
    best_dist_nxt = take_cand ? cand    : best_dist;
    best_idx_nxt  = take_cand ? sel_idx : best_idx;
  end

  // The result is computed from the final scan step so that digit/distance
  // are already valid in the cycle done is high.
`ifdef DIGIT_MATCH_REJECT_EN
  assign result_digit = (best_dist_nxt > DIST_W'(REJECT_THRESH)) ? REJECT_CODE
                                                                   : best_idx_nxt;
`else
  logic [DIST_W-1:0] unused_thresh;
  assign unused_thresh = DIST_W'(REJECT_THRESH);
  assign result_digit  = best_idx_nxt;
`endif

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt   <= '0;
      sel_idx   <= '0;
      best_dist <= '0;
      best_idx  <= '0;
      digit     <= '0;
      distance  <= '0;
      done      <= 1'b0;
      for (int d = 0; d < NUM_DIGITS; d++) acc[d] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            row_cnt <= '0;
            sel_idx <= '0;
            for (int d = 0; d < NUM_DIGITS; d++) acc[d] <= '0;
          end
        end
        ACCUM: begin
          for (int d = 0; d < NUM_DIGITS; d++) begin
            acc[d] <= acc[d] + DIST_W'(row_diff[d]);
          end
          // Wraps to 0 after row 15, leaving row_addr at 0 outside ACCUM.
          row_cnt <= row_cnt + 4'd1;
          sel_idx <= '0;
        end
        SELECT: begin
          best_dist <= best_dist_nxt;
          best_idx  <= best_idx_nxt;
          sel_idx   <= sel_idx + 4'd1;
          if (sel_idx == 4'(NUM_DIGITS - 1)) begin
            digit    <= result_digit;
            distance <= best_dist_nxt;
            done     <= 1'b1;
          end
        end
        DONE: begin
          sel_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign row_addr = row_cnt;
  assign busy     = (state != IDLE);

endmodule
